trinity_generation_scheduler: RTL and testbench

Sequences one trinity evolution engine and one external fitness evaluator over a small on-chip population of ternary weight vectors (64 bits = 32 trits, 2 bits per trit). Per offspring the block:
- picks two parents by 2-way tournament;
- issues them to the engine and captures the child;
- requests a fitness score;
- replaces the current worst individual if the child scores strictly higher.

It sits between the host/config logic and the evolution datapath.

---
 rtl/trinity_evo_pkg.sv | 30 +++
 rtl/trinity_pop_argext.sv | 26 ++
 rtl/trinity_generation_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_trinity_generation_scheduler.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trinity_evo_pkg.sv
// Shared types and constants for the trinity evolution datapath.
package trinity_evo_pkg;

  localparam int unsigned TRIT_W   = 2;
  localparam int unsigned WEIGHT_W = 64;
  localparam int unsigned SCORE_W  = 32;

  typedef enum logic [TRIT_W-1:0] {
    NEG  = 2'b00,
    ZERO = 2'b01,
    POS  = 2'b10
  } trit_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEL,
    ST_ISSUE,
    ST_WAIT_ENG,
    ST_EVAL,
    ST_WAIT_FIT,
    ST_REPLACE,
    ST_FIN
  } sched_state_e;

  // 32-bit Fibonacci LFSR step, taps 32,22,2,1.
  function automatic logic [31:0] lfsr_next(input logic [31:0] l);
    return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
  endfunction

endpackage

// File: rtl/trinity_pop_argext.sv
// Combinational argmax/argmin over the population scores; lowest index wins ties.
module trinity_pop_argext
  import trinity_evo_pkg::*;
#(
  parameter int unsigned POP_SIZE = 8,
  parameter int unsigned IDX_W    = $clog2(POP_SIZE),
  parameter bit          FIND_MAX = 1'b1
) (
  input  logic [SCORE_W-1:0] scores [POP_SIZE],
  output logic [IDX_W-1:0]   idx,
  output logic [SCORE_W-1:0] score
);

  // Linear scan; strict compare keeps the earliest index on equal scores.
  always_comb begin
    idx   = '0;
    score = scores[0];
    for (int unsigned i = 1; i < POP_SIZE; i++) begin
      if (FIND_MAX ? (scores[i] > score) : (scores[i] < score)) begin
        idx   = IDX_W'(i);
        score = scores[i];
      end
    end
  end

endmodule

// File: rtl/trinity_generation_scheduler.sv
// Generation scheduler: tournament selection, engine/evaluator handshakes,
// worst-entry replacement over an on-chip population.
module trinity_generation_scheduler
  import trinity_evo_pkg::*;
#(
  parameter int unsigned POP_SIZE  = 8,
  parameter int unsigned IDX_W     = $clog2(POP_SIZE),
  parameter logic [31:0] LFSR_SEED = 32'h1F35
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ld_en,
  input  logic [IDX_W-1:0]    ld_idx,
  input  logic [WEIGHT_W-1:0] ld_weights,
  input  logic [SCORE_W-1:0]  ld_score,
  input  logic                start,
  input  logic [15:0]         gen_limit,
  output logic                eng_start,
  output logic [WEIGHT_W-1:0] eng_parent_a,
  output logic [WEIGHT_W-1:0] eng_parent_b,
  input  logic                eng_done,
  input  logic [WEIGHT_W-1:0] eng_child,
  output logic                fit_req,
  output logic [WEIGHT_W-1:0] fit_weights,
  input  logic                fit_valid,
  input  logic [SCORE_W-1:0]  fit_score,
  output logic                busy,
  output logic                done,
  output logic [15:0]         gen_count,
  output logic [IDX_W-1:0]    best_idx,
  output logic [SCORE_W-1:0]  best_score
);

  localparam logic [IDX_W-1:0] LAST_CHILD = IDX_W'(POP_SIZE - 1);

  sched_state_e        state_q, state_d;
  logic [31:0]         lfsr_q, lfsr_d;
  logic [SCORE_W-1:0]  scores_q [POP_SIZE];
  logic [SCORE_W-1:0]  scores_d [POP_SIZE];
  logic [WEIGHT_W-1:0] weights_q [POP_SIZE];
  logic [WEIGHT_W-1:0] weights_d [POP_SIZE];
  logic [WEIGHT_W-1:0] parent_a_q, parent_a_d;
  logic [WEIGHT_W-1:0] parent_b_q, parent_b_d;
  logic [WEIGHT_W-1:0] fit_weights_q, fit_weights_d;
  logic [SCORE_W-1:0]  child_score_q, child_score_d;
  logic [15:0]         gen_count_q, gen_count_d;
  logic [15:0]         gen_limit_q, gen_limit_d;
  logic [IDX_W-1:0]    child_cnt_q, child_cnt_d;
  logic                done_q, done_d;

  logic [IDX_W-1:0]    worst_idx;
  logic [SCORE_W-1:0]  worst_score;
  logic [IDX_W-1:0]    cand0, cand1, cand2, cand3;
  logic [IDX_W-1:0]    win_a, win_b;

  // 2-way tournament: higher score wins, lower index on equal scores.
  function automatic logic [IDX_W-1:0] pick(input logic [IDX_W-1:0]   a,
                                            input logic [IDX_W-1:0]   b,
                                            input logic [SCORE_W-1:0] sa,
                                            input logic [SCORE_W-1:0] sb);
    if (sb > sa)      return b;
    else if (sa > sb) return a;
    else              return (a < b) ? a : b;
  endfunction

  trinity_pop_argext #(.POP_SIZE(POP_SIZE), .IDX_W(IDX_W), .FIND_MAX(1'b1)) u_best (
    .scores (scores_q),
    .idx    (best_idx),
    .score  (best_score)
  );

  trinity_pop_argext #(.POP_SIZE(POP_SIZE), .IDX_W(IDX_W), .FIND_MAX(1'b0)) u_worst (
    .scores (scores_q),
    .idx    (worst_idx),
    .score  (worst_score)
  );

  // Tournament candidates drawn from consecutive LFSR bit fields.
  always_comb begin
    cand0 = lfsr_q[IDX_W-1:0];
    cand1 = lfsr_q[2*IDX_W-1:IDX_W];
    cand2 = lfsr_q[3*IDX_W-1:2*IDX_W];
    cand3 = lfsr_q[4*IDX_W-1:3*IDX_W];
    win_a = pick(cand0, cand1, scores_q[cand0], scores_q[cand1]);
    win_b = pick(cand2, cand3, scores_q[cand2], scores_q[cand3]);
  end

  // Next-state and datapath updates for the scheduler FSM.
  always_comb begin
    state_d       = state_q;
    lfsr_d        = lfsr_next(lfsr_q);
    scores_d      = scores_q;
    weights_d     = weights_q;
    parent_a_d    = parent_a_q;
    parent_b_d    = parent_b_q;
    fit_weights_d = fit_weights_q;
    child_score_d = child_score_q;
    gen_count_d   = gen_count_q;
    gen_limit_d   = gen_limit_q;
    child_cnt_d   = child_cnt_q;
    done_d        = (state_q == ST_FIN);
    case (state_q)
      ST_IDLE: begin
        if (ld_en) begin
          scores_d[ld_idx]  = ld_score;
          weights_d[ld_idx] = ld_weights;
        end
        if (start) begin
          gen_limit_d = gen_limit;
          gen_count_d = '0;
          child_cnt_d = '0;
          state_d     = (gen_limit == 16'd0) ? ST_FIN : ST_SEL;
        end
      end
      ST_SEL: begin
        parent_a_d = weights_q[win_a];
        parent_b_d = weights_q[win_b];
        state_d    = ST_ISSUE;
      end
      ST_ISSUE: state_d = ST_WAIT_ENG;
      ST_WAIT_ENG: begin
        if (eng_done) begin
          fit_weights_d = eng_child;
          state_d       = ST_EVAL;
        end
      end
      ST_EVAL: state_d = ST_WAIT_FIT;
      ST_WAIT_FIT: begin
        if (fit_valid) begin
          child_score_d = fit_score;
          state_d       = ST_REPLACE;
        end
      end
      ST_REPLACE: begin
        if (child_score_q > worst_score) begin
          scores_d[worst_idx]  = child_score_q;
          weights_d[worst_idx] = fit_weights_q;
        end
        child_cnt_d = child_cnt_q + 1'b1;
        if (child_cnt_q == LAST_CHILD) gen_count_d = gen_count_q + 16'd1;
        state_d = (gen_count_d == gen_limit_q) ? ST_FIN : ST_SEL;
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      lfsr_q        <= LFSR_SEED;
      scores_q      <= '{default: '0};
      weights_q     <= '{default: '0};
      parent_a_q    <= '0;
      parent_b_q    <= '0;
      fit_weights_q <= '0;
      child_score_q <= '0;
      gen_count_q   <= '0;
      gen_limit_q   <= '0;
      child_cnt_q   <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      lfsr_q        <= lfsr_d;
      scores_q      <= scores_d;
      weights_q     <= weights_d;
      parent_a_q    <= parent_a_d;
      parent_b_q    <= parent_b_d;
      fit_weights_q <= fit_weights_d;
      child_score_q <= child_score_d;
      gen_count_q   <= gen_count_d;
      gen_limit_q   <= gen_limit_d;
      child_cnt_q   <= child_cnt_d;
      done_q        <= done_d;
    end
  end

  assign eng_start    = (state_q == ST_ISSUE);
  assign fit_req      = (state_q == ST_EVAL) || (state_q == ST_WAIT_FIT);
  assign busy         = (state_q != ST_IDLE);
  assign done         = done_q;
  assign gen_count    = gen_count_q;
  assign eng_parent_a = parent_a_q;
  assign eng_parent_b = parent_b_q;
  assign fit_weights  = fit_weights_q;

endmodule

// File: tb/tb_trinity_generation_scheduler.sv
// Self-checking bench: reference population model plus a scoreboard of
// expected post-replacement results.
module tb_trinity_generation_scheduler;

  localparam int unsigned N     = 8;
  localparam logic [31:0] SEED  = 32'h1F35;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_en;
  logic [2:0]  ld_idx;
  logic [63:0] ld_weights;
  logic [31:0] ld_score;
  logic        start;
  logic [15:0] gen_limit;
  logic        eng_start;
  logic [63:0] eng_parent_a, eng_parent_b;
  logic        eng_done;
  logic [63:0] eng_child;
  logic        fit_req;
  logic [63:0] fit_weights;
  logic        fit_valid;
  logic [31:0] fit_score;
  logic        busy, done;
  logic [15:0] gen_count;
  logic [2:0]  best_idx;
  logic [31:0] best_score;

  trinity_generation_scheduler #(.POP_SIZE(N), .LFSR_SEED(SEED)) dut (
    .clk(clk), .reset(reset), .ld_en(ld_en), .ld_idx(ld_idx),
    .ld_weights(ld_weights), .ld_score(ld_score), .start(start),
    .gen_limit(gen_limit), .eng_start(eng_start), .eng_parent_a(eng_parent_a),
    .eng_parent_b(eng_parent_b), .eng_done(eng_done), .eng_child(eng_child),
    .fit_req(fit_req), .fit_weights(fit_weights), .fit_valid(fit_valid),
    .fit_score(fit_score), .busy(busy), .done(done), .gen_count(gen_count),
    .best_idx(best_idx), .best_score(best_score)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;

  // Reference model state.
  logic [31:0] m_lfsr, m_prev;
  logic [31:0] m_score [N];
  logic [63:0] m_w     [N];
  int          m_child;

  typedef struct packed {
    logic [2:0]  idx;
    logic [31:0] score;
    logic [15:0] gen;
  } exp_t;
  exp_t sb[$];

  function automatic logic [31:0] ref_lfsr(input logic [31:0] l);
    return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
  endfunction

  // Model LFSR runs in lockstep with the DUT; m_prev is last cycle's value.
  always @(posedge clk) begin
    m_prev <= m_lfsr;
    if (reset) m_lfsr <= SEED;
    else       m_lfsr <= ref_lfsr(m_lfsr);
  end

  always @(posedge clk) if (done) done_cnt++;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic int ref_pick(input int a, input int b);
    if (m_score[b] > m_score[a]) return b;
    if (m_score[a] > m_score[b]) return a;
    return (a < b) ? a : b;
  endfunction

  function automatic int ref_worst();
    int w = 0;
    for (int i = 1; i < N; i++) if (m_score[i] < m_score[w]) w = i;
    return w;
  endfunction

  function automatic int ref_best();
    int b = 0;
    for (int i = 1; i < N; i++) if (m_score[i] > m_score[b]) b = i;
    return b;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_score[i] = '0;
      m_w[i]     = '0;
    end
  endtask

  task automatic load(input int idx, input logic [63:0] w, input logic [31:0] s);
    ld_en = 1'b1; ld_idx = 3'(idx); ld_weights = w; ld_score = s;
    tick();
    ld_en = 1'b0;
    m_w[idx] = w; m_score[idx] = s;
  endtask

  task automatic start_run(input logic [15:0] lim);
    start = 1'b1; gen_limit = lim;
    tick();
    start = 1'b0;
    m_child = 0;
  endtask

  // Serve one offspring: check parents, answer engine and evaluator, then
  // compare best entry and generation count against the scoreboard.
  task automatic serve_child(input int eng_dly, input int fit_dly,
                             input logic [31:0] sc, input logic [63:0] cw,
                             input bit spurious);
    bit found = 0;
    int ea, eb, w, extra_start;
    logic [63:0] pa, pb;
    exp_t e;
    for (int i = 0; i < 100 && !found; i++) begin
      if (eng_start) found = 1;
      else tick();
    end
    if (!found) begin
      check_eq("eng_start_timeout", 64'd0, 64'd1);
      return;
    end
    ea = ref_pick(int'(m_prev[2:0]), int'(m_prev[5:3]));
    eb = ref_pick(int'(m_prev[8:6]), int'(m_prev[11:9]));
    check_eq("parent_a", eng_parent_a, m_w[ea]);
    check_eq("parent_b", eng_parent_b, m_w[eb]);
    pa = eng_parent_a; pb = eng_parent_b;
    tick();
    extra_start = 0;
    for (int d = 0; d < eng_dly; d++) begin
      if (eng_start) extra_start++;
      tick();
    end
    check_eq("eng_start_single", 64'(extra_start), 64'd0);
    check_eq("parents_stable", {eng_parent_a ^ pa} | {eng_parent_b ^ pb}, 64'd0);
    eng_done = 1'b1; eng_child = cw;
    tick();
    eng_done = 1'b0; eng_child = '0;
    check_eq("fit_req_eval", 64'(fit_req), 64'd1);
    check_eq("fit_weights", fit_weights, cw);
    tick();
    for (int d = 0; d < fit_dly; d++) begin
      check_eq("fit_req_hold", 64'(fit_req), 64'd1);
      if (spurious && d == 1) begin
        eng_done = 1'b1; eng_child = ~cw;
      end else begin
        eng_done = 1'b0;
      end
      tick();
    end
    eng_done = 1'b0;
    fit_valid = 1'b1; fit_score = sc;
    w = ref_worst();
    if (sc > m_score[w]) begin
      m_score[w] = sc; m_w[w] = cw;
    end
    m_child++;
    e.idx = 3'(ref_best()); e.score = m_score[ref_best()]; e.gen = 16'(m_child / N);
    sb.push_back(e);
    tick();
    fit_valid = 1'b0; fit_score = '0;
    check_eq("fit_req_drop", 64'(fit_req), 64'd0);
    check_eq("fit_weights_kept", fit_weights, cw);
    tick();
    e = sb.pop_front();
    check_eq("best_idx", 64'(best_idx), 64'(e.idx));
    check_eq("best_score", 64'(best_score), 64'(e.score));
    check_eq("gen_count", 64'(gen_count), 64'(e.gen));
  endtask

  task automatic finish_run(input int done_before, input logic [15:0] gens);
    tick(); tick();
    check_eq("done_once", 64'(done_cnt - done_before), 64'd1);
    check_eq("gen_final", 64'(gen_count), 64'(gens));
    check_eq("busy_end", 64'(busy), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int d0;
    logic [31:0] t1 [N];
    t1 = '{5, 9, 1, 9, 3, 7, 2, 8};
    reset = 1'b1; ld_en = 0; ld_idx = 0; ld_weights = 0; ld_score = 0;
    start = 0; gen_limit = 0; eng_done = 0; eng_child = 0; fit_valid = 0; fit_score = 0;
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < N; i++) begin m_score[i] = '0; m_w[i] = '0; end
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_gen", 64'(gen_count), 64'd0);
    check_eq("rst_fit_req", 64'(fit_req), 64'd0);
    check_eq("rst_eng_start", 64'(eng_start), 64'd0);
    check_eq("rst_parents", eng_parent_a | eng_parent_b | fit_weights, 64'd0);
    check_eq("rst_best", 64'(best_score), 64'd0);

    // Test 1: observe best entry only.
    for (int i = 0; i < N; i++) load(i, 64'h1111_0000_0000_0000 + 64'(i * 17), t1[i]);
    check_eq("t1_best_idx", 64'(best_idx), 64'd1);
    check_eq("t1_best_score", 64'(best_score), 64'd9);

    // Test 2: one generation, every child outscores the current worst.
    d0 = done_cnt;
    start_run(16'd1);
    for (int c = 0; c < N; c++) serve_child(1, 1, 32'd100, 64'hC0DE_0000_0000_0000 | 64'(c), 1'b0);
    finish_run(d0, 16'd1);
    check_eq("t2_best_idx", 64'(best_idx), 64'd0);
    check_eq("t2_best_score", 64'(best_score), 64'd100);

    // Test 3: equal scores never replace.
    do_reset();
    for (int i = 0; i < N; i++) load(i, 64'h3333_0000_0000_0000 + 64'(i), 32'd50);
    d0 = done_cnt;
    start_run(16'd1);
    for (int c = 0; c < N; c++) serve_child(0, 0, 32'd50, 64'hDEAD_0000_0000_0000 | 64'(c), 1'b0);
    finish_run(d0, 16'd1);

    // Test 4: zero generation limit finishes immediately.
    d0 = done_cnt;
    start = 1'b1; gen_limit = 16'd0;
    tick();
    start = 1'b0;
    check_eq("t4_busy_fin", 64'(busy), 64'd1);
    check_eq("t4_done_early", 64'(done), 64'd0);
    check_eq("t4_no_eng", 64'(eng_start), 64'd0);
    tick();
    check_eq("t4_done", 64'(done), 64'd1);
    check_eq("t4_idle", 64'(busy), 64'd0);
    tick();
    check_eq("t4_done_low", 64'(done), 64'd0);
    check_eq("t4_done_cnt", 64'(done_cnt - d0), 64'd1);
    check_eq("t4_gen", 64'(gen_count), 64'd0);

    // Test 5: long engine/evaluator waits with a stray eng_done in WAIT_FIT.
    do_reset();
    for (int i = 0; i < N; i++) load(i, 64'h5555_0000_0000_0000 + 64'(i), 32'(10 * (i + 1)));
    d0 = done_cnt;
    start_run(16'd1);
    serve_child(20, 5, 32'd1000, 64'hBEEF_0000_0000_0001, 1'b1);
    for (int c = 1; c < N; c++)
      serve_child(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  32'($urandom_range(0, 120)), 64'hBEEF_0000_0000_0000 | 64'(c << 4), 1'b0);
    finish_run(d0, 16'd1);

    // Test 6: reset while waiting for the engine.
    for (int i = 0; i < N; i++) load(i, 64'h6666_0000_0000_0000 + 64'(i), 32'(i + 3));
    start_run(16'd1);
    tick(); tick(); tick();
    check_eq("t6_in_run", 64'(busy), 64'd1);
    do_reset();
    check_eq("t6_idle", 64'(busy), 64'd0);
    check_eq("t6_scores", 64'(best_score), 64'd0);
    check_eq("t6_gen", 64'(gen_count), 64'd0);
    eng_done = 1'b1; eng_child = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    eng_done = 1'b0;
    tick();
    check_eq("t6_stray_busy", 64'(busy), 64'd0);
    check_eq("t6_stray_fit", fit_weights, 64'd0);
    check_eq("t6_stray_req", 64'(fit_req | eng_start), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
